// File: rtl/bicubic_hpass_accum.sv
// Horizontal pass of a bicubic scaler: weights four vertical-pass columns, rounds,
// clamps to a pixel channel, and tracks line position and saturation events.
module bicubic_hpass_accum #(
  parameter int CHANNEL_WIDTH       = 8,
  parameter int INTER_PRODUCT_WIDTH = 24,
  parameter int LINE_PIXELS         = 3840
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [2:0]                            w1,
  input  logic [2:0]                            w2,
  input  logic [2:0]                            w3,
  input  logic [2:0]                            w4,
  input  logic signed [INTER_PRODUCT_WIDTH-1:0] inner_product1,
  input  logic signed [INTER_PRODUCT_WIDTH-1:0] inner_product2,
  input  logic signed [INTER_PRODUCT_WIDTH-1:0] inner_product3,
  input  logic signed [INTER_PRODUCT_WIDTH-1:0] inner_product4,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [CHANNEL_WIDTH-1:0]              out_pixel,
  output logic                                  out_last,
  output logic [15:0]                           sat_cnt
);

  localparam int PW = INTER_PRODUCT_WIDTH + 8;
  localparam int SW = INTER_PRODUCT_WIDTH + 10;
  localparam int VW = SW - 14;
  localparam logic [11:0] LAST_POS = 12'(LINE_PIXELS - 1);
  localparam logic signed [VW-1:0] PIX_MAX = VW'((1 << CHANNEL_WIDTH) - 1);

  // Coefficients are in units of 1/128; the four taps of a phase sum to 128.
  function automatic logic signed [7:0] coef(input logic [2:0] code);
    case (code)
      3'd0:    coef = 8'sd0;
      3'd1:    coef = -8'sd1;
      3'd2:    coef = -8'sd6;
      3'd3:    coef = -8'sd9;
      3'd4:    coef = 8'sd12;
      3'd5:    coef = 8'sd50;
      3'd6:    coef = 8'sd93;
      default: coef = 8'sd123;
    endcase
  endfunction

  logic [2:0]                            codes [4];
  logic signed [INTER_PRODUCT_WIDTH-1:0] ips [4];
  logic signed [PW-1:0]                  prod_next [4];
  logic signed [PW-1:0]                  prod_reg [4];

  assign codes[0] = w1;
  assign codes[1] = w2;
  assign codes[2] = w3;
  assign codes[3] = w4;
  assign ips[0]   = inner_product1;
  assign ips[1]   = inner_product2;
  assign ips[2]   = inner_product3;
  assign ips[3]   = inner_product4;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign prod_next[gi] = PW'(ips[gi]) * PW'(coef(codes[gi]));
    end
  endgenerate

  logic s1_valid;
  logic s1_advance;
  logic s2_advance;
  logic beat_done;

  assign s2_advance = !out_valid || out_ready;
  assign s1_advance = !s1_valid || s2_advance;
  assign in_ready   = s1_advance;
  assign beat_done  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      for (int i = 0; i < 4; i++) prod_reg[i] <= '0;
    end else if (s1_advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < 4; i++) prod_reg[i] <= prod_next[i];
      end
    end
  end

  // Sum width leaves two guard bits, so four worst-case products cannot overflow.
  logic signed [SW-1:0]        sum_next;
  logic signed [SW-1:0]        rounded_next;
  logic signed [VW-1:0]        shifted_next;
  logic [CHANNEL_WIDTH-1:0]    pixel_next;
  logic                        sat_next;

  assign sum_next     = SW'(prod_reg[0]) + SW'(prod_reg[1]) + SW'(prod_reg[2]) + SW'(prod_reg[3]);
  assign rounded_next = sum_next + SW'(8192);
  assign shifted_next = rounded_next[SW-1:14];

  always_comb begin
    pixel_next = shifted_next[CHANNEL_WIDTH-1:0];
    sat_next   = 1'b0;
    if (shifted_next < 0) begin
      pixel_next = '0;
      sat_next   = 1'b1;
    end else if (shifted_next > PIX_MAX) begin
      pixel_next = '1;
      sat_next   = 1'b1;
    end
  end

  logic        sat_flag_reg;
  logic [11:0] line_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_pixel    <= '0;
      sat_flag_reg <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_pixel    <= pixel_next;
        sat_flag_reg <= sat_next;
      end
    end
  end

  // Position and saturation are charged only when the downstream takes the beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_cnt_reg <= '0;
      sat_cnt      <= '0;
    end else if (beat_done) begin
      line_cnt_reg <= (line_cnt_reg == LAST_POS) ? 12'd0 : line_cnt_reg + 12'd1;
      if (sat_flag_reg && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
    end
  end

  assign out_last = out_valid && (line_cnt_reg == LAST_POS);

endmodule

// File: tb/tb_bicubic_hpass_accum.sv
// Directed and random stimulus for bicubic_hpass_accum with a queue-based reference
// scoreboard; LINE_PIXELS is reduced to 4 so line wraps happen quickly.
module tb_bicubic_hpass_accum;
  localparam int CW  = 8;
  localparam int IPW = 24;
  localparam int LP  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [2:0] w1 = '0, w2 = '0, w3 = '0, w4 = '0;
  logic signed [IPW-1:0] ip1 = '0, ip2 = '0, ip3 = '0, ip4 = '0;
  logic in_ready, out_valid, out_last;
  logic [CW-1:0] out_pixel;
  logic [15:0] sat_cnt;

  bicubic_hpass_accum #(.CHANNEL_WIDTH(CW), .INTER_PRODUCT_WIDTH(IPW), .LINE_PIXELS(LP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .w1(w1), .w2(w2), .w3(w3), .w4(w4),
    .inner_product1(ip1), .inner_product2(ip2), .inner_product3(ip3), .inner_product4(ip4),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_last(out_last), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] pix;
    logic          sat;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  int exp_sat = 0, tb_line = 0, n_out = 0, win_cnt = 0;
  bit acc, held;
  logic [CW-1:0] held_pix;
  logic held_last;
  logic [31:0] last_log;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint coef(input logic [2:0] c);
    case (c)
      3'd0: return 0;
      3'd1: return -1;
      3'd2: return -6;
      3'd3: return -9;
      3'd4: return 12;
      3'd5: return 50;
      3'd6: return 93;
      default: return 123;
    endcase
  endfunction

  function automatic exp_t model();
    longint s, v;
    exp_t e;
    s = coef(w1) * longint'(ip1) + coef(w2) * longint'(ip2)
      + coef(w3) * longint'(ip3) + coef(w4) * longint'(ip4);
    v = (s + 64'sd8192) >>> 14;
    e.sat = (v < 0) || (v > 255);
    if (v < 0) e.pix = '0;
    else if (v > 255) e.pix = 8'hFF;
    else e.pix = v[CW-1:0];
    return e;
  endfunction

  task automatic set_beat(input int c1, c2, c3, c4, input int a, b, c, d);
    w1 = 3'(c1); w2 = 3'(c2); w3 = 3'(c3); w4 = 3'(c4);
    ip1 = IPW'(a); ip2 = IPW'(b); ip3 = IPW'(c); ip4 = IPW'(d);
  endtask

  task automatic rand_beat();
    set_beat($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             int'($urandom_range(0, 100000)) - 50000, int'($urandom_range(0, 100000)) - 50000,
             int'($urandom_range(0, 100000)) - 50000, int'($urandom_range(0, 100000)) - 50000);
  endtask

  // Observe the cycle at the falling edge, then advance to just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    acc = 1'b0;
    if (rst_n) begin
      chk("sat_cnt", sat_cnt, exp_sat);
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_pixel", out_pixel, held_pix);
        chk("hold_last", out_last, held_last);
      end
      held = out_valid && !out_ready;
      held_pix = out_pixel;
      held_last = out_last;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("pixel", out_pixel, e.pix);
          chk("last", out_last, (tb_line == LP - 1) ? 1 : 0);
          tb_line = (tb_line == LP - 1) ? 0 : tb_line + 1;
          if (e.sat && exp_sat != 65535) exp_sat++;
          if (win_cnt < 32) last_log[win_cnt] = out_last;
          win_cnt++;
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model());
        acc = 1'b1;
      end
    end else begin
      sb.delete();
      tb_line = 0;
      exp_sat = 0;
      held = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget = 0;
    in_valid = 1'b0;
    while (sb.size() > 0 && budget < 50) begin
      tick();
      budget++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    int k, start;
    // Reset state
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_pixel", out_pixel, 0);
    chk("rst_last", out_last, 0);
    chk("rst_sat", sat_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Nominal beat with latency check
    set_beat(2, 7, 4, 1, 12800, 12800, 12800, 12800);
    in_valid = 1'b1;
    tick();
    chk("nominal_acc", acc, 1);
    in_valid = 1'b0;
    chk("lat_c1_valid", out_valid, 0);
    tick();
    chk("lat_c2_valid", out_valid, 1);
    chk("nominal_pix", out_pixel, 100);
    drain();
    chk("nominal_sat", sat_cnt, 0);

    // High and low clamps
    set_beat(3, 6, 5, 0, 38400, 38400, 38400, 38400);
    in_valid = 1'b1;
    tick();
    drain();
    chk("high_sat", sat_cnt, 1);
    set_beat(2, 7, 4, 1, -1280, -1280, -1280, -1280);
    in_valid = 1'b1;
    tick();
    drain();
    chk("low_sat", sat_cnt, 2);

    // Backpressure: four distinct beats against a stalled output
    start = n_out;
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      set_beat(2, 7, 4, 1, 2000 * (k + 1), 2000 * (k + 1), 2000 * (k + 1), 2000 * (k + 1));
      in_valid = 1'b1;
      tick();
      if (acc) k++;
    end
    chk("bp_accepted", k, 2);
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && k < 4; c++) begin
      set_beat(2, 7, 4, 1, 2000 * (k + 1), 2000 * (k + 1), 2000 * (k + 1), 2000 * (k + 1));
      in_valid = 1'b1;
      tick();
      if (acc) k++;
    end
    drain();
    chk("bp_outputs", n_out - start, 4);

    // Line wrap over ten back-to-back beats from line position 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    win_cnt = 0;
    last_log = '0;
    for (int i = 0; i < 10; i++) begin
      rand_beat();
      in_valid = 1'b1;
      tick();
      chk("bb_acc", acc, 1);
    end
    drain();
    chk("wrap_count", win_cnt, 10);
    chk("wrap_last_mask", last_log[9:0], 10'b0010001000);

    // Reset with two beats in flight, after the line position and sat_cnt moved
    set_beat(3, 6, 5, 0, 38400, 38400, 38400, 38400);
    in_valid = 1'b1;
    tick();
    drain();
    chk("pre_rst_sat_nonzero", (sat_cnt != 0) ? 1 : 0, 1);
    rand_beat();
    in_valid = 1'b1;
    tick();
    rand_beat();
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sat", sat_cnt, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    win_cnt = 0;
    last_log = '0;
    for (int i = 0; i < 4; i++) begin
      rand_beat();
      in_valid = 1'b1;
      tick();
    end
    drain();
    chk("mid_rst_last_mask", last_log[3:0], 4'b1000);

    // Random traffic with random backpressure; a refused beat is held unchanged
    acc = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (acc || !in_valid) begin
        rand_beat();
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
